// File: rtl/data_memory.sv
// rtl/data_memory.sv - single-port data memory with post-reset self-clear and registered read
module data_memory #(
  parameter int A_BITS         = 10,
  parameter int D_BITS         = 32,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              read_i,
  input  logic              write_i,
  input  logic [A_BITS-1:0] address_i,
  input  logic [D_BITS-1:0] data_in_i,
  output logic [D_BITS-1:0] data_out_o,
  output logic              read_valid_o,
  output logic              ready_o
);

  localparam int DEPTH = 2 ** A_BITS;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state;
  state_t state_next;

  logic [A_BITS-1:0] clr_ptr;
  logic              clr_last;
  logic              clear_en;
  logic              req_en;
  logic              mem_we;
  logic [A_BITS-1:0] mem_addr;
  logic [D_BITS-1:0] mem_wdata;

  logic [D_BITS-1:0] mem [DEPTH];

  // The clear sweep ends on the word with the all-ones address.
  assign clr_last = (clr_ptr == '1);

  // State register: reset selects clearing or straight to service.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= CLEAR_ON_RESET ? INIT : RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state: leave INIT once the last word has been cleared.
  always_comb begin
    state_next = state;
    if (state == INIT && clr_last) begin
      state_next = RUN;
    end
  end

  // Control decode: the clear sweep owns the write port in INIT, requests own it in RUN.
  always_comb begin
    clear_en  = 1'b0;
    req_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = address_i;
    mem_wdata = data_in_i;
    if (rst_i) begin
      if (state == INIT) begin
        clear_en  = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = clr_ptr;
        mem_wdata = '0;
      end else begin
        req_en = 1'b1;
        mem_we = write_i;
      end
    end
  end

  // Clear pointer walks the array once per edge while clearing.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      clr_ptr <= '0;
    end else if (clear_en) begin
      clr_ptr <= clr_ptr + 1'b1;
    end
  end

  // Ready tracks whether the next cycle will be serviced.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ready_o <= 1'b0;
    end else begin
      ready_o <= (state_next == RUN);
    end
  end

  // Storage array; deliberately not reset so it can map onto block RAM.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  // Registered read port, write-first when read and write coincide.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      data_out_o   <= '0;
      read_valid_o <= 1'b0;
    end else if (req_en && read_i) begin
      data_out_o   <= write_i ? data_in_i : mem[address_i];
      read_valid_o <= 1'b1;
    end else begin
      read_valid_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_memory.sv
// tb/tb_data_memory.sv - randomized model-based bench for data_memory (clearing and non-clearing)
module tb_data_memory;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic [1:0]  rst;
  logic [1:0]  rd;
  logic [1:0]  wr;
  logic [9:0]  addr [2];
  logic [31:0] din  [2];

  logic [31:0] dout_a, dout_b;
  logic        vld_a, vld_b, rdy_a, rdy_b;

  // reference model state, one slot per instance (0 = clears, 1 = keeps contents)
  logic [31:0] mm [2][DEPTH];
  int          clr_left [2];
  logic        m_rdy [2];
  logic        m_vld [2];
  logic [31:0] m_dout [2];
  bit          clears [2] = '{1'b1, 1'b0};

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  data_memory #(.A_BITS(10), .D_BITS(32), .CLEAR_ON_RESET(1'b1)) dut_a (
    .clk_i(clk), .rst_i(rst[0]), .read_i(rd[0]), .write_i(wr[0]),
    .address_i(addr[0]), .data_in_i(din[0]),
    .data_out_o(dout_a), .read_valid_o(vld_a), .ready_o(rdy_a)
  );

  data_memory #(.A_BITS(10), .D_BITS(32), .CLEAR_ON_RESET(1'b0)) dut_b (
    .clk_i(clk), .rst_i(rst[1]), .read_i(rd[1]), .write_i(wr[1]),
    .address_i(addr[1]), .data_in_i(din[1]),
    .data_out_o(dout_b), .read_valid_o(vld_b), .ready_o(rdy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  // Reference behaviour: after reset a clearing memory needs DEPTH serviced-free edges,
  // then every edge applies the write and returns the post-write word for a read.
  task automatic model_edge(input int k);
    if (!rst[k]) begin
      clr_left[k] = clears[k] ? DEPTH : 0;
      m_rdy[k]    = 1'b0;
      m_vld[k]    = 1'b0;
      m_dout[k]   = '0;
    end else if (clr_left[k] > 0) begin
      clr_left[k]--;
      m_vld[k] = 1'b0;
      if (clr_left[k] == 0) begin
        for (int j = 0; j < DEPTH; j++) mm[k][j] = '0;
        m_rdy[k] = 1'b1;
      end
    end else begin
      m_rdy[k] = 1'b1;
      if (wr[k]) mm[k][addr[k]] = din[k];
      if (rd[k]) begin
        m_dout[k] = mm[k][addr[k]];
        m_vld[k]  = 1'b1;
      end else begin
        m_vld[k] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check("a_ready", {31'd0, rdy_a}, {31'd0, m_rdy[0]});
    check("a_valid", {31'd0, vld_a}, {31'd0, m_vld[0]});
    check("a_data", dout_a, m_dout[0]);
    check("b_ready", {31'd0, rdy_b}, {31'd0, m_rdy[1]});
    check("b_valid", {31'd0, vld_b}, {31'd0, m_vld[1]});
    check("b_data", dout_b, m_dout[1]);
    cyc++;
  endtask

  task automatic drive(input int k, input logic r, input logic w, input logic [9:0] a, input logic [31:0] d);
    rd[k]   = r;
    wr[k]   = w;
    addr[k] = a;
    din[k]  = d;
  endtask

  task automatic drive_random(input int k, input bit any_addr);
    logic [9:0] a;
    a = any_addr ? 10'($urandom_range(0, DEPTH - 1)) : 10'($urandom_range(0, 15));
    drive(k, 1'($urandom), 1'($urandom), a, $urandom);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      clr_left[k] = 0;
      m_rdy[k]    = 1'b0;
      m_vld[k]    = 1'b0;
      m_dout[k]   = '0;
      drive(k, 1'b0, 1'b0, 10'd0, 32'd0);
    end
    rst = 2'b00;
    step();
    step();

    // A clears (with a reset pulse at INIT cycle 500) while B is filled word by word
    rst = 2'b11;
    for (int i = 0; i < 1600; i++) begin
      rst[0] = (i == 500) ? 1'b0 : 1'b1;
      if (i == 10) drive(0, 1'b0, 1'b1, 10'h020, 32'hAAAAAAAA);
      else         drive_random(0, 1'b1);
      if (i < DEPTH) drive(1, 1'b0, 1'b1, 10'(i), $urandom);
      else           drive(1, 1'b0, 1'b0, 10'd0, 32'd0);
      step();
    end
    rst = 2'b11;

    // directed sequences on A
    drive(1, 1'b0, 1'b0, 10'd0, 32'd0);
    drive(0, 1'b1, 1'b0, 10'h3FF, 32'd0);        step();
    drive(0, 1'b1, 1'b0, 10'h020, 32'd0);        step();
    drive(0, 1'b0, 1'b1, 10'h005, 32'hDEADBEEF); step();
    drive(0, 1'b1, 1'b0, 10'h005, 32'd0);        step();
    drive(0, 1'b0, 1'b0, 10'h005, 32'd0);        step();
    step();
    drive(0, 1'b1, 1'b1, 10'h010, 32'h12345678); step();
    drive(0, 1'b0, 1'b0, 10'h000, 32'd0);        step();
    drive(0, 1'b1, 1'b0, 10'h010, 32'd0);        step();
    drive(0, 1'b0, 1'b1, 10'h000, 32'h11111111); step();
    drive(0, 1'b0, 1'b1, 10'h3FF, 32'h22222222); step();
    drive(0, 1'b1, 1'b0, 10'h3FF, 32'd0);        step();
    drive(0, 1'b1, 1'b0, 10'h000, 32'd0);        step();
    drive(0, 1'b0, 1'b0, 10'h000, 32'd0);        step();

    // mixed random traffic, half of it concentrated on a few words for hazards
    for (int i = 0; i < 2000; i++) begin
      drive_random(0, i[0]);
      drive_random(1, i[1]);
      step();
    end

    // B: reset mid-RUN drops the read and the write, contents survive
    drive(0, 1'b0, 1'b0, 10'd0, 32'd0);
    drive(1, 1'b1, 1'b0, 10'h001, 32'd0);        step();
    drive(1, 1'b0, 1'b1, 10'h001, 32'h5A5A5A5A); step();
    drive(1, 1'b1, 1'b1, 10'h001, 32'h0BADF00D);
    rst[1] = 1'b0;                               step();
    rst[1] = 1'b1;
    drive(1, 1'b0, 1'b0, 10'h001, 32'd0);        step();
    drive(1, 1'b1, 1'b0, 10'h001, 32'd0);        step();
    drive(1, 1'b0, 1'b0, 10'h001, 32'd0);        step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
